pc_unit: RTL and testbench

//  Parametrised program-counter unit for the rv32imc core; replaces the bare PC register.

---
 rtl/pc_unit.sv | 150 +++++++++++++++
 tb/tb_pc_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit -- program-counter unit for the rv32imc core.
// Holds the fetch PC and selects the next PC: sequential +2/+4, taken
// branch/jump redirect, or trap vector. It also sequences boot, halts on a
// misaligned redirect target, and captures the EPC on trap entry.
//
// Optional feature macro: PC_RAS_EN adds a RAS_DEPTH-entry circular
// return-address stack. Without it, ras_top=0 and ras_empty=1.
//
// Ports:
//   clk, arstn                      clock (rising edge), async active-low reset
//   stall                           blocks sequential advance only
//   fetch_ready                     instruction memory accepts request at pc
//   instr_compressed                instruction at pc is 16-bit (C_EXT only)
//   redirect_valid/redirect_target  taken branch/jump
//   trap_valid/trap_vector          trap/interrupt entry
//   ras_push/ras_pop                call/return stack operations
//   pc, fetch_valid                 current fetch PC and request valid
//   epc, misaligned                 PC at last trap, halted on bad target
//   ras_top, ras_empty              return-address stack view
module pc_unit #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter bit                C_EXT        = 1'b1,
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            arstn,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            instr_compressed,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic            fetch_valid,
  output logic [XLEN-1:0] epc,
  output logic            misaligned,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  // Clears the address bits that must be zero for a legal instruction address.
  localparam logic [XLEN-1:0] ALIGN_MASK = C_EXT ? ~XLEN'(1) : ~XLEN'(3);

  state_t          stateQ, stateD;
  logic [XLEN-1:0] pcD, epcD, seqPc, len;
  logic            misD, aligned, redirTaken, advTaken;

  assign fetch_valid = (stateQ == RUN) & ~stall;
  assign len         = (C_EXT && instr_compressed) ? XLEN'(2) : XLEN'(4);
  assign seqPc       = pc + len;
  assign aligned     = (redirect_target & ~ALIGN_MASK) == '0;

  always_comb begin
    stateD     = stateQ;
    pcD        = pc;
    epcD       = epc;
    misD       = misaligned;
    redirTaken = 1'b0;
    advTaken   = 1'b0;
    if (trap_valid) begin
      epcD   = pc;
      pcD    = trap_vector & ALIGN_MASK;
      stateD = RUN;
      misD   = 1'b0;
    end else begin
      unique case (stateQ)
        BOOT: stateD = RUN;
        RUN: begin
          // A redirect wins over stall/fetch_ready: the branch has already resolved.
          if (redirect_valid) begin
            if (aligned) begin
              redirTaken = 1'b1;
              pcD        = redirect_target;
            end else begin
              misD   = 1'b1;
              stateD = HALT;
            end
          end else if (fetch_valid && fetch_ready) begin
            advTaken = 1'b1;
            pcD      = seqPc;
          end
        end
        HALT: ;
        default: stateD = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      stateQ     <= BOOT;
      pc         <= RESET_VECTOR;
      epc        <= '0;
      misaligned <= 1'b0;
    end else begin
      stateQ     <= stateD;
      pc         <= pcD;
      epc        <= epcD;
      misaligned <= misD;
    end
  end

`ifdef PC_RAS_EN
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW + 1)'(RAS_DEPTH);

  logic [XLEN-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]   topPtr, nextPtr, prevPtr;
  logic [PW:0]     count;
  logic            pushEn, popEn;

  assign pushEn  = ras_push & (advTaken | redirTaken);
  assign popEn   = ras_pop & (count != '0);
  assign nextPtr = topPtr + 1'b1;
  assign prevPtr = topPtr - 1'b1;

  // Circular buffer: a push when full advances over the oldest entry.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      topPtr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
    end else if (pushEn && popEn) begin
      stack[topPtr] <= seqPc;
    end else if (pushEn) begin
      topPtr         <= nextPtr;
      stack[nextPtr] <= seqPc;
      if (count != FULL) count <= count + 1'b1;
    end else if (popEn) begin
      topPtr <= prevPtr;
      count  <= count - 1'b1;
    end
  end

  assign ras_empty = (count == '0);
  assign ras_top   = ras_empty ? '0 : stack[topPtr];
`else
  logic unusedRas;
  assign unusedRas = ras_push ^ ras_pop ^ redirTaken ^ advTaken;
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit (default parameters: XLEN=32, RESET_VECTOR=0, C_EXT=1,
// RAS_DEPTH=4). Directed scenarios followed by random traffic, all checked
// against a flag-and-queue reference model. Stack checks apply with PC_RAS_EN.
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        arstn, stall, fetch_ready, instr_compressed;
  logic        redirect_valid, trap_valid, ras_push, ras_pop;
  logic [31:0] redirect_target, trap_vector;
  logic [31:0] pc, epc, ras_top;
  logic        fetch_valid, misaligned, ras_empty;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [31:0] mPc, mEpc;
  logic        mMis, mBoot, mHalt;
  logic [31:0] mStack[$];

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1'b1), .RAS_DEPTH(4)) dut (
    .clk(clk), .arstn(arstn), .stall(stall), .fetch_ready(fetch_ready),
    .instr_compressed(instr_compressed), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .trap_valid(trap_valid),
    .trap_vector(trap_vector), .ras_push(ras_push), .ras_pop(ras_pop),
    .pc(pc), .fetch_valid(fetch_valid), .epc(epc), .misaligned(misaligned),
    .ras_top(ras_top), .ras_empty(ras_empty));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expTop();
`ifdef PC_RAS_EN
    return (mStack.size() == 0) ? 32'h0 : mStack[mStack.size() - 1];
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic expEmpty();
`ifdef PC_RAS_EN
    return mStack.size() == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic modelReset();
    mPc = 32'h0; mEpc = 32'h0; mMis = 1'b0; mBoot = 1'b1; mHalt = 1'b0;
    mStack.delete();
  endtask

  task automatic checkAll(input string tag);
    chk({tag, "_pc"}, pc, mPc);
    chk({tag, "_epc"}, epc, mEpc);
    chk({tag, "_mis"}, {31'b0, misaligned}, {31'b0, mMis});
    chk({tag, "_rastop"}, ras_top, expTop());
    chk({tag, "_rasempty"}, {31'b0, ras_empty}, {31'b0, expEmpty()});
  endtask

  // Apply the current inputs for one clock edge and update the model.
  task automatic modelEdge();
    logic running, pushOk;
    logic [31:0] len;
    running = !mBoot && !mHalt;
    len     = instr_compressed ? 32'd2 : 32'd4;
    pushOk  = !trap_valid && running &&
              (redirect_valid ? (redirect_target[0] == 1'b0) : (!stall && fetch_ready));
    if (ras_push && pushOk && ras_pop && mStack.size() > 0) begin
      mStack[mStack.size() - 1] = mPc + len;
    end else if (ras_push && pushOk) begin
      mStack.push_back(mPc + len);
      if (mStack.size() > 4) void'(mStack.pop_front());
    end else if (ras_pop && mStack.size() > 0) begin
      void'(mStack.pop_back());
    end
    if (trap_valid) begin
      mEpc = mPc; mPc = {trap_vector[31:1], 1'b0};
      mBoot = 1'b0; mHalt = 1'b0; mMis = 1'b0;
    end else if (mBoot) begin
      mBoot = 1'b0;
    end else if (running && redirect_valid) begin
      if (redirect_target[0]) begin mMis = 1'b1; mHalt = 1'b1; end
      else mPc = redirect_target;
    end else if (running && !stall && fetch_ready) begin
      mPc = mPc + len;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(input string tag);
    #1;
    chk({tag, "_fv"}, {31'b0, fetch_valid}, {31'b0, (!mBoot && !mHalt && !stall)});
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(tag);
    @(negedge clk);
  endtask

  task automatic idle();
    stall = 0; fetch_ready = 0; instr_compressed = 0; redirect_valid = 0;
    redirect_target = 0; trap_valid = 0; trap_vector = 0; ras_push = 0; ras_pop = 0;
  endtask

  task automatic doReset();
    idle();
    arstn = 1'b0;
    modelReset();
    #3;
    checkAll("rst");
    chk("rst_fv", {31'b0, fetch_valid}, 32'h0);
    @(negedge clk);
    arstn = 1'b1;
  endtask

  initial begin
    arstn = 1'b1;
    idle();
    @(negedge clk);
    doReset();

    // T1: boot cycle, then sequential 4-byte advance
    fetch_ready = 1;
    step("t1_boot");
    chk("t1_pc0", pc, 32'h0);
    step("t1_a"); chk("t1_pc4", pc, 32'h4);
    step("t1_b"); chk("t1_pc8", pc, 32'h8);
    step("t1_c"); chk("t1_pcC", pc, 32'hC);

    // T2: compressed mix from pc=0
    doReset();
    fetch_ready = 1;
    step("t2_boot");
    instr_compressed = 1; step("t2_a"); chk("t2_pc2", pc, 32'h2);
    instr_compressed = 0; step("t2_b"); chk("t2_pc6", pc, 32'h6);
    instr_compressed = 1; step("t2_c"); chk("t2_pc8", pc, 32'h8);
    instr_compressed = 0;

    // T3: stall holds pc; redirect overrides stall
    stall = 1; step("t3_hold"); chk("t3_pc8", pc, 32'h8);
    redirect_valid = 1; redirect_target = 32'h100;
    step("t3_redir"); chk("t3_pc100", pc, 32'h100);
    stall = 0;

    // T4: misaligned target halts; trap recovers
    redirect_target = 32'h40; step("t4_to40");
    redirect_target = 32'h103; step("t4_bad");
    chk("t4_mis", {31'b0, misaligned}, 32'h1);
    chk("t4_pc40", pc, 32'h40);
    redirect_valid = 0; step("t4_halted");
    chk("t4_fv0", {31'b0, fetch_valid}, 32'h0);
    trap_valid = 1; trap_vector = 32'h203; step("t4_trap");
    chk("t4_pc202", pc, 32'h202);
    chk("t4_epc40", epc, 32'h40);
    trap_valid = 0; #1;
    chk("t4_fv1", {31'b0, fetch_valid}, 32'h1);

    // T5: trap beats redirect; wrap-around at the top of the address space
    trap_valid = 1; trap_vector = 32'h300; redirect_valid = 1; redirect_target = 32'h500;
    step("t5_both"); chk("t5_pc300", pc, 32'h300);
    trap_valid = 0; redirect_target = 32'hFFFF_FFFC; step("t5_top");
    redirect_valid = 0; step("t5_wrap"); chk("t5_pc0", pc, 32'h0);

`ifdef PC_RAS_EN
    // T6: overflowing pushes then pops down to empty
    doReset();
    fetch_ready = 1;
    step("t6_boot");
    redirect_valid = 1; redirect_target = 32'h10; step("t6_to10");
    for (int i = 2; i <= 5; i++) begin
      ras_push = 1; redirect_target = 32'(i * 16); step("t6_push");
    end
    redirect_valid = 0; step("t6_push5");
    ras_push = 0;
    chk("t6_top54", ras_top, 32'h54);
    ras_pop = 1;
    step("t6_pop1"); chk("t6_top44", ras_top, 32'h44);
    step("t6_pop2"); chk("t6_top34", ras_top, 32'h34);
    step("t6_pop3"); chk("t6_top24", ras_top, 32'h24);
    step("t6_pop4"); chk("t6_empty", {31'b0, ras_empty}, 32'h1);
    step("t6_pop5"); chk("t6_top0", ras_top, 32'h0);
    ras_pop = 0;
`endif

    // Async reset mid-cycle takes effect without a clock edge
    fetch_ready = 1; step("ar_pre");
    #3 arstn = 1'b0;
    #1 modelReset();
    checkAll("ar");
    chk("ar_fv", {31'b0, fetch_valid}, 32'h0);
    @(negedge clk);
    arstn = 1'b1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      stall            = ($urandom % 4) == 0;
      fetch_ready      = ($urandom % 4) != 0;
      instr_compressed = $urandom % 2;
      redirect_valid   = ($urandom % 8) == 0;
      redirect_target  = $urandom;
      trap_valid       = ($urandom % 24) == 0;
      trap_vector      = $urandom;
      ras_push         = ($urandom % 3) == 0;
      ras_pop          = ($urandom % 4) == 0;
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
